// File: rtl/wishbone_mem_interconnect_n_if.sv
// rtl/wishbone_mem_interconnect_n_if.sv - bus bundle between one master, the interconnect and four slave ports
//
// Purpose: groups the master request/response signals and the four slave
//          request/response groups (N = 0..3) into one interface.
// Signals:
//   m_we_i, m_cyc_i, m_stb_i, m_sel_i[3:0], m_adr_i[31:0], m_dat_i[31:0]  master request
//   m_ack_o, m_dat_o[31:0], m_int_o, m_err_o                              master response
//   sN_we_o, sN_cyc_o, sN_stb_o, sN_sel_o[3:0], sN_adr_o, sN_dat_o[31:0]  slave N request
//   sN_ack_i, sN_int_i, sN_dat_i[31:0]                                    slave N response
// Modports:
//   slave  - the interconnect's view (it is the bus slave of the master)
//   master - the environment's view (drives master request and slave responses)
interface wishbone_mem_interconnect_n_if;
   logic        m_we_i, m_cyc_i, m_stb_i;
   logic [3:0]  m_sel_i;
   logic [31:0] m_adr_i, m_dat_i;
   logic        m_ack_o, m_int_o, m_err_o;
   logic [31:0] m_dat_o;

   logic        s0_we_o, s0_cyc_o, s0_stb_o, s0_ack_i, s0_int_i;
   logic [3:0]  s0_sel_o;
   logic [31:0] s0_adr_o, s0_dat_o, s0_dat_i;
   logic        s1_we_o, s1_cyc_o, s1_stb_o, s1_ack_i, s1_int_i;
   logic [3:0]  s1_sel_o;
   logic [31:0] s1_adr_o, s1_dat_o, s1_dat_i;
   logic        s2_we_o, s2_cyc_o, s2_stb_o, s2_ack_i, s2_int_i;
   logic [3:0]  s2_sel_o;
   logic [31:0] s2_adr_o, s2_dat_o, s2_dat_i;
   logic        s3_we_o, s3_cyc_o, s3_stb_o, s3_ack_i, s3_int_i;
   logic [3:0]  s3_sel_o;
   logic [31:0] s3_adr_o, s3_dat_o, s3_dat_i;

   modport slave (
      input  m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
      output m_ack_o, m_dat_o, m_int_o, m_err_o,
      output s0_we_o, s0_cyc_o, s0_stb_o, s0_sel_o, s0_adr_o, s0_dat_o,
      input  s0_ack_i, s0_int_i, s0_dat_i,
      output s1_we_o, s1_cyc_o, s1_stb_o, s1_sel_o, s1_adr_o, s1_dat_o,
      input  s1_ack_i, s1_int_i, s1_dat_i,
      output s2_we_o, s2_cyc_o, s2_stb_o, s2_sel_o, s2_adr_o, s2_dat_o,
      input  s2_ack_i, s2_int_i, s2_dat_i,
      output s3_we_o, s3_cyc_o, s3_stb_o, s3_sel_o, s3_adr_o, s3_dat_o,
      input  s3_ack_i, s3_int_i, s3_dat_i
   );

   modport master (
      output m_we_i, m_cyc_i, m_stb_i, m_sel_i, m_adr_i, m_dat_i,
      input  m_ack_o, m_dat_o, m_int_o, m_err_o,
      input  s0_we_o, s0_cyc_o, s0_stb_o, s0_sel_o, s0_adr_o, s0_dat_o,
      output s0_ack_i, s0_int_i, s0_dat_i,
      input  s1_we_o, s1_cyc_o, s1_stb_o, s1_sel_o, s1_adr_o, s1_dat_o,
      output s1_ack_i, s1_int_i, s1_dat_i,
      input  s2_we_o, s2_cyc_o, s2_stb_o, s2_sel_o, s2_adr_o, s2_dat_o,
      output s2_ack_i, s2_int_i, s2_dat_i,
      input  s3_we_o, s3_cyc_o, s3_stb_o, s3_sel_o, s3_adr_o, s3_dat_o,
      output s3_ack_i, s3_int_i, s3_dat_i
   );
endinterface

// File: rtl/wishbone_mem_interconnect_n.sv
// rtl/wishbone_mem_interconnect_n.sv - single-master Wishbone interconnect decoding up to four memory windows
//
// Purpose: decodes each master request against NUM_SLAVES address windows,
//          forwards it to the lowest matching slave, answers misses with a
//          one-cycle zero-data ack, and ORs slave interrupts into m_int_o.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - wishbone_mem_interconnect_n_if.slave (master side plus slave ports 0..3)
// Configuration macro:
//   WB_MEM_INTERCONNECT_TIMEOUT_EN - enables the slave-ack watchdog and the
//   ERR_ACK error response; undefined means ACTIVE waits indefinitely.
module wishbone_mem_interconnect_n #(
   parameter int          NUM_SLAVES     = 2,
   parameter logic [31:0] MEM_OFFSET_0   = 32'h0000_0000,
   parameter logic [31:0] MEM_OFFSET_1   = 32'h0000_1000,
   parameter logic [31:0] MEM_OFFSET_2   = 32'h0000_2000,
   parameter logic [31:0] MEM_OFFSET_3   = 32'h0000_3000,
   parameter logic [31:0] MEM_SIZE_0     = 32'd4096,
   parameter logic [31:0] MEM_SIZE_1     = 32'd4096,
   parameter logic [31:0] MEM_SIZE_2     = 32'd4096,
   parameter logic [31:0] MEM_SIZE_3     = 32'd4096,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
   input logic                           clk,
   input logic                           rst,
   wishbone_mem_interconnect_n_if.slave  bus
);

   if (NUM_SLAVES < 1 || NUM_SLAVES > 4 || TIMEOUT_CYCLES == 16'd0) begin : g_cfg_check
      $error("wishbone_mem_interconnect_n: NUM_SLAVES must be 1..4 and TIMEOUT_CYCLES nonzero");
   end

`ifdef WB_MEM_INTERCONNECT_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, ACTIVE, MISS_ACK, ERR_ACK} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACTIVE, MISS_ACK} state_t;
`endif

   // Interrupt lines of ports at or above NUM_SLAVES never reach m_int_o.
   localparam logic [3:0] L_INT_MASK = 4'((5'd1 << NUM_SLAVES) - 5'd1);

   state_t      r_state;
   logic [1:0]  r_sel;
   logic        r_int;
`ifdef WB_MEM_INTERCONNECT_TIMEOUT_EN
   logic [15:0] r_wdog;
`endif

   logic [3:0]  w_s_ack, w_s_int;
   logic [31:0] w_s_dat [4];
   logic [3:0]  w_o_we, w_o_cyc, w_o_stb;
   logic [3:0]  w_o_sel [4];
   logic [31:0] w_o_adr [4];
   logic [31:0] w_o_dat [4];
   logic        w_hit, w_sel_ack, w_m_ack, w_m_err;
   logic [1:0]  w_idx;
   logic [31:0] w_m_dat;

   assign w_s_ack    = {bus.s3_ack_i, bus.s2_ack_i, bus.s1_ack_i, bus.s0_ack_i};
   assign w_s_int    = {bus.s3_int_i, bus.s2_int_i, bus.s1_int_i, bus.s0_int_i};
   assign w_s_dat[0] = bus.s0_dat_i;
   assign w_s_dat[1] = bus.s1_dat_i;
   assign w_s_dat[2] = bus.s2_dat_i;
   assign w_s_dat[3] = bus.s3_dat_i;
   assign w_sel_ack  = w_s_ack[r_sel];

   // Window bounds are held in 33 bits so a window touching the top of the
   // address space does not wrap its upper bound to zero.
   function automatic logic [32:0] f_lo(input int n);
      case (n)
         0:       f_lo = {1'b0, MEM_OFFSET_0};
         1:       f_lo = {1'b0, MEM_OFFSET_1};
         2:       f_lo = {1'b0, MEM_OFFSET_2};
         default: f_lo = {1'b0, MEM_OFFSET_3};
      endcase
   endfunction

   function automatic logic [32:0] f_hi(input int n);
      case (n)
         0:       f_hi = f_lo(n) + {1'b0, MEM_SIZE_0};
         1:       f_hi = f_lo(n) + {1'b0, MEM_SIZE_1};
         2:       f_hi = f_lo(n) + {1'b0, MEM_SIZE_2};
         default: f_hi = f_lo(n) + {1'b0, MEM_SIZE_3};
      endcase
   endfunction

   // Scan from the highest port down so the lowest matching port wins.
   always_comb begin
      w_hit = 1'b0;
      w_idx = 2'd0;
      for (int n = 3; n >= 0; n--) begin
         if (n < NUM_SLAVES &&
             {1'b0, bus.m_adr_i} >= f_lo(n) && {1'b0, bus.m_adr_i} < f_hi(n)) begin
            w_hit = 1'b1;
            w_idx = 2'(n);
         end
      end
   end

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         w_o_we[n]  = 1'b0;
         w_o_cyc[n] = 1'b0;
         w_o_stb[n] = 1'b0;
         w_o_sel[n] = 4'd0;
         w_o_adr[n] = 32'd0;
         w_o_dat[n] = 32'd0;
      end
      w_m_ack = 1'b0;
      w_m_err = 1'b0;
      w_m_dat = 32'd0;
      case (r_state)
         ACTIVE: begin
            for (int n = 0; n < NUM_SLAVES; n++) begin
               if (r_sel == 2'(n)) begin
                  w_o_we[n]  = bus.m_we_i;
                  w_o_cyc[n] = bus.m_cyc_i;
                  w_o_stb[n] = bus.m_stb_i;
                  w_o_sel[n] = bus.m_sel_i;
                  w_o_adr[n] = bus.m_adr_i;
                  w_o_dat[n] = bus.m_dat_i;
               end
            end
            w_m_ack = w_sel_ack;
            w_m_dat = w_s_dat[r_sel];
         end
         MISS_ACK: w_m_ack = 1'b1;
`ifdef WB_MEM_INTERCONNECT_TIMEOUT_EN
         ERR_ACK: begin
            w_m_ack = 1'b1;
            w_m_err = 1'b1;
            w_m_dat = 32'hFFFF_FFFF;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_sel   <= 2'd0;
         r_int   <= 1'b0;
`ifdef WB_MEM_INTERCONNECT_TIMEOUT_EN
         r_wdog  <= 16'd0;
`endif
      end else begin
         r_int <= |(w_s_int & L_INT_MASK);
         case (r_state)
            IDLE: begin
               if (bus.m_cyc_i && bus.m_stb_i) begin
                  if (w_hit) begin
                     r_state <= ACTIVE;
                     r_sel   <= w_idx;
`ifdef WB_MEM_INTERCONNECT_TIMEOUT_EN
                     r_wdog  <= 16'd0;
`endif
                  end else begin
                     r_state <= MISS_ACK;
                  end
               end
            end
            ACTIVE: begin
               // An ack is checked before the watchdog, so an ack landing on
               // the limit cycle completes normally.
               if (w_sel_ack || !bus.m_cyc_i) begin
                  r_state <= IDLE;
               end
`ifdef WB_MEM_INTERCONNECT_TIMEOUT_EN
               else begin
                  r_wdog <= r_wdog + 16'd1;
                  if (r_wdog + 16'd1 == TIMEOUT_CYCLES) begin
                     r_state <= ERR_ACK;
                  end
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.m_ack_o  = w_m_ack;
   assign bus.m_dat_o  = w_m_dat;
   assign bus.m_err_o  = w_m_err;
   assign bus.m_int_o  = r_int;

   assign bus.s0_we_o  = w_o_we[0];
   assign bus.s0_cyc_o = w_o_cyc[0];
   assign bus.s0_stb_o = w_o_stb[0];
   assign bus.s0_sel_o = w_o_sel[0];
   assign bus.s0_adr_o = w_o_adr[0];
   assign bus.s0_dat_o = w_o_dat[0];
   assign bus.s1_we_o  = w_o_we[1];
   assign bus.s1_cyc_o = w_o_cyc[1];
   assign bus.s1_stb_o = w_o_stb[1];
   assign bus.s1_sel_o = w_o_sel[1];
   assign bus.s1_adr_o = w_o_adr[1];
   assign bus.s1_dat_o = w_o_dat[1];
   assign bus.s2_we_o  = w_o_we[2];
   assign bus.s2_cyc_o = w_o_cyc[2];
   assign bus.s2_stb_o = w_o_stb[2];
   assign bus.s2_sel_o = w_o_sel[2];
   assign bus.s2_adr_o = w_o_adr[2];
   assign bus.s2_dat_o = w_o_dat[2];
   assign bus.s3_we_o  = w_o_we[3];
   assign bus.s3_cyc_o = w_o_cyc[3];
   assign bus.s3_stb_o = w_o_stb[3];
   assign bus.s3_sel_o = w_o_sel[3];
   assign bus.s3_adr_o = w_o_adr[3];
   assign bus.s3_dat_o = w_o_dat[3];

endmodule

// File: tb/tb_wishbone_mem_interconnect_n.sv
// tb/tb_wishbone_mem_interconnect_n.sv - self-checking bench for wishbone_mem_interconnect_n
module tb_wishbone_mem_interconnect_n;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   wishbone_mem_interconnect_n_if bus ();
   wishbone_mem_interconnect_n_if bus1 ();

   wishbone_mem_interconnect_n #(.NUM_SLAVES(2), .TIMEOUT_CYCLES(16'd8)) dut (
      .clk(clk), .rst(rst), .bus(bus));
   wishbone_mem_interconnect_n #(.NUM_SLAVES(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1);
   end

   // Reference decode: lowest window n < nsl with base <= adr and adr-base < 4096.
   function automatic int model_decode(input logic [31:0] adr, input int nsl);
      logic [31:0] base [4];
      base[0] = 32'h0000; base[1] = 32'h1000; base[2] = 32'h2000; base[3] = 32'h3000;
      for (int n = 0; n < nsl; n++)
         if (adr >= base[n] && (adr - base[n]) < 32'd4096) return n;
      return -1;
   endfunction

   function automatic logic [3:0] stb_vec();
      return {bus.s3_stb_o, bus.s2_stb_o, bus.s1_stb_o, bus.s0_stb_o};
   endfunction

   function automatic logic quiet();
      return ({bus.s0_we_o, bus.s0_cyc_o, bus.s0_stb_o, bus.s0_sel_o, bus.s0_adr_o, bus.s0_dat_o,
               bus.s1_we_o, bus.s1_cyc_o, bus.s1_stb_o, bus.s1_sel_o, bus.s1_adr_o, bus.s1_dat_o,
               bus.s2_we_o, bus.s2_cyc_o, bus.s2_stb_o, bus.s2_sel_o, bus.s2_adr_o, bus.s2_dat_o,
               bus.s3_we_o, bus.s3_cyc_o, bus.s3_stb_o, bus.s3_sel_o, bus.s3_adr_o, bus.s3_dat_o} == '0);
   endfunction

   function automatic logic fwd_match(input int n, input logic we, input logic [3:0] sel,
                                      input logic [31:0] adr, input logic [31:0] dat);
      case (n)
         0: return bus.s0_cyc_o && bus.s0_we_o == we && bus.s0_sel_o == sel && bus.s0_adr_o == adr && bus.s0_dat_o == dat;
         1: return bus.s1_cyc_o && bus.s1_we_o == we && bus.s1_sel_o == sel && bus.s1_adr_o == adr && bus.s1_dat_o == dat;
         2: return bus.s2_cyc_o && bus.s2_we_o == we && bus.s2_sel_o == sel && bus.s2_adr_o == adr && bus.s2_dat_o == dat;
         default: return bus.s3_cyc_o && bus.s3_we_o == we && bus.s3_sel_o == sel && bus.s3_adr_o == adr && bus.s3_dat_o == dat;
      endcase
   endfunction

   task automatic set_ack(input int n, input logic v, input logic [31:0] d);
      case (n)
         0: begin bus.s0_ack_i = v; bus.s0_dat_i = d; end
         1: begin bus.s1_ack_i = v; bus.s1_dat_i = d; end
         2: begin bus.s2_ack_i = v; bus.s2_dat_i = d; end
         default: begin bus.s3_ack_i = v; bus.s3_dat_i = d; end
      endcase
   endtask

   task automatic clear_acks();
      for (int n = 0; n < 4; n++) set_ack(n, 1'b0, $urandom());
   endtask

   // One master transfer; the addressed slave acks on strobe cycle delay+1.
   task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int delay, input logic [31:0] rdat,
                          output logic ack, output logic err, output logic [31:0] odat,
                          output logic [3:0] stb_mask, output int first_stb,
                          output int stb_cycles, output logic fwd_ok);
      logic [3:0] w;
      int n;
      ack = 1'b0; err = 1'b0; odat = 32'd0; stb_mask = 4'd0;
      first_stb = -1; stb_cycles = 0; fwd_ok = 1'b1;
      @(negedge clk);
      bus.m_we_i = we; bus.m_adr_i = adr; bus.m_dat_i = dat; bus.m_sel_i = sel;
      bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         w = stb_vec();
         stb_mask |= w;
         if (w != 4'd0) begin
            if (first_stb < 0) first_stb = c;
            stb_cycles++;
            n = (w == 4'b0001) ? 0 : (w == 4'b0010) ? 1 : (w == 4'b0100) ? 2 : 3;
            if ($countones(w) != 1 || !fwd_match(n, we, sel, adr, dat)) fwd_ok = 1'b0;
            if (stb_cycles > delay) set_ack(n, 1'b1, rdat);
         end
         #1;
         if (bus.m_ack_o) begin
            ack = 1'b1; err = bus.m_err_o; odat = bus.m_dat_o;
            break;
         end
      end
      @(posedge clk);
      #1;
      clear_acks();
      bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.s0_int_i = 1'b1; bus.s1_int_i = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.m_ack_o !== 1'b0 || bus.m_err_o !== 1'b0 || bus.m_dat_o !== 32'd0 || bus.m_int_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_master_outputs: ack=%b err=%b dat=%h int=%b required 0/0/0/0",
                  bus.m_ack_o, bus.m_err_o, bus.m_dat_o, bus.m_int_o);
      end
      checks++;
      if (quiet() !== 1'b1) begin
         errors++;
         $display("FAIL reset_slave_outputs: quiet=%b required 1", quiet());
      end
      bus.s0_int_i = 1'b0; bus.s1_int_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_idle_ack_ignored();
      @(negedge clk);
      set_ack(0, 1'b1, 32'h1234_5678);
      set_ack(1, 1'b1, 32'h8765_4321);
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus.m_ack_o !== 1'b0 || bus.m_dat_o !== 32'd0) begin
            errors++;
            $display("FAIL idle_ack_ignored: ack=%b dat=%h required 0/0", bus.m_ack_o, bus.m_dat_o);
         end
      end
      clear_acks();
   endtask

   task automatic test_read_s1();
      logic ack, err, fwd; logic [31:0] d; logic [3:0] m; int f, sc;
      do_xfer(1'b0, 32'h1004, 32'h0, 4'hF, 3, 32'hA5A5_A5A5, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || err !== 1'b0 || d !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL read_s1_resp: ack=%b err=%b dat=%h required 1/0/a5a5a5a5", ack, err, d);
      end
      checks++;
      if (m !== 4'b0010 || f != 1 || sc != 4 || fwd !== 1'b1) begin
         errors++;
         $display("FAIL read_s1_strobe: mask=%b first=%0d cycles=%0d fwd=%b required 0010/1/4/1", m, f, sc, fwd);
      end
   endtask

   task automatic test_boundary();
      logic ack, err, fwd; logic [31:0] d; logic [3:0] m; int f, sc;
      do_xfer(1'b1, 32'h0FFF, 32'h1234_5678, 4'h3, 0, 32'h0, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || m !== 4'b0001 || fwd !== 1'b1 || f != 1) begin
         errors++;
         $display("FAIL boundary_0fff: ack=%b mask=%b fwd=%b first=%0d required 1/0001/1/1", ack, m, fwd, f);
      end
      do_xfer(1'b1, 32'h1000, 32'hCAFE_F00D, 4'hC, 1, 32'h0, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || m !== 4'b0010 || fwd !== 1'b1 || f != 1) begin
         errors++;
         $display("FAIL boundary_1000: ack=%b mask=%b fwd=%b first=%0d required 1/0010/1/1", ack, m, fwd, f);
      end
   endtask

   task automatic test_miss();
      logic ack, err, fwd; logic [31:0] d; logic [3:0] m; int f, sc;
      set_ack(0, 1'b0, 32'hDEAD_BEEF);
      do_xfer(1'b0, 32'h8000, 32'h0, 4'hF, 0, 32'h5555_5555, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || err !== 1'b0 || d !== 32'd0 || m !== 4'd0) begin
         errors++;
         $display("FAIL miss_8000: ack=%b err=%b dat=%h mask=%b required 1/0/0/0000", ack, err, d, m);
      end
      checks++;
      if (bus.m_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL miss_one_cycle: ack=%b required 0", bus.m_ack_o);
      end
   endtask

   task automatic test_random();
      logic ack, err, fwd, we; logic [31:0] d, adr, dat, rdat; logic [3:0] m, sel;
      int f, sc, delay, exp;
      logic [31:0] edges [5];
      edges[0] = 32'h0FFF; edges[1] = 32'h1000; edges[2] = 32'h1FFF; edges[3] = 32'h2000; edges[4] = 32'h0;
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: adr = 32'($urandom_range(0, 32'h3FFF));
            1: adr = edges[$urandom_range(0, 4)];
            2: adr = $urandom();
            3: adr = 32'h1000 + 32'($urandom_range(0, 4095));
            default: adr = 32'($urandom_range(0, 4095));
         endcase
         we = 1'($urandom_range(0, 1)); dat = $urandom(); sel = 4'($urandom_range(0, 15));
         delay = $urandom_range(0, 3); rdat = $urandom();
         exp = model_decode(adr, 2);
         do_xfer(we, adr, dat, sel, delay, rdat, ack, err, d, m, f, sc, fwd);
         checks++;
         if (ack !== 1'b1 || err !== 1'b0 || d !== ((exp < 0) ? 32'd0 : rdat)) begin
            errors++;
            $display("FAIL rand_resp[%0d] adr=%h: ack=%b err=%b dat=%h required 1/0/%h",
                     i, adr, ack, err, d, (exp < 0) ? 32'd0 : rdat);
         end
         checks++;
         if (m !== ((exp < 0) ? 4'd0 : 4'(1 << exp))) begin
            errors++;
            $display("FAIL rand_route[%0d] adr=%h: mask=%b required slave %0d", i, adr, m, exp);
         end
         if (exp >= 0) begin
            checks++;
            if (f != 1 || sc != delay + 1 || fwd !== 1'b1) begin
               errors++;
               $display("FAIL rand_timing[%0d]: first=%0d cycles=%0d fwd=%b required 1/%0d/1", i, f, sc, fwd, delay + 1);
            end
         end
      end
   endtask

   task automatic test_abort_and_reset();
      logic ack, err, fwd; logic [31:0] d; logic [3:0] m; int f, sc;
      @(negedge clk);
      bus.m_we_i = 1'b0; bus.m_adr_i = 32'h1010; bus.m_sel_i = 4'hF; bus.m_dat_i = 32'h0;
      bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (stb_vec() !== 4'b0010) begin
         errors++;
         $display("FAIL abort_pre_strobe: mask=%b required 0010", stb_vec());
      end
      bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
      #1;
      checks++;
      if (bus.m_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_ack: ack=%b required 0", bus.m_ack_o);
      end
      @(negedge clk);
      checks++;
      if (quiet() !== 1'b1 || bus.m_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: quiet=%b ack=%b required 1/0", quiet(), bus.m_ack_o);
      end
      bus.m_cyc_i = 1'b1; bus.m_stb_i = 1'b1; bus.m_adr_i = 32'h0020;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (quiet() !== 1'b1 || bus.m_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_active: quiet=%b ack=%b required 1/0", quiet(), bus.m_ack_o);
      end
      @(negedge clk);
      bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0;
      rst = 1'b1;
      do_xfer(1'b0, 32'h0024, 32'h0, 4'hF, 1, 32'h0BAD_F00D, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || d !== 32'h0BAD_F00D || m !== 4'b0001) begin
         errors++;
         $display("FAIL after_reset_xfer: ack=%b dat=%h mask=%b required 1/0badf00d/0001", ack, d, m);
      end
   endtask

   task automatic test_watchdog();
      logic ack, err, fwd; logic [31:0] d; logic [3:0] m; int f, sc;
      // Ack on the 8th strobe cycle coincides with the watchdog limit (8).
      do_xfer(1'b0, 32'h0040, 32'h0, 4'hF, 7, 32'h7777_0008, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || err !== 1'b0 || d !== 32'h7777_0008 || sc != 8) begin
         errors++;
         $display("FAIL ack_at_limit: ack=%b err=%b dat=%h cycles=%0d required 1/0/77770008/8", ack, err, d, sc);
      end
`ifdef WB_MEM_INTERCONNECT_TIMEOUT_EN
      do_xfer(1'b0, 32'h0010, 32'h0, 4'hF, 1000, 32'h0, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || err !== 1'b1 || d !== 32'hFFFF_FFFF || sc != 8) begin
         errors++;
         $display("FAIL timeout_err: ack=%b err=%b dat=%h cycles=%0d required 1/1/ffffffff/8", ack, err, d, sc);
      end
`else
      do_xfer(1'b0, 32'h0010, 32'h0, 4'hF, 1000, 32'h0, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b0 || sc != 40) begin
         errors++;
         $display("FAIL no_timeout_wait: ack=%b cycles=%0d required 0/40", ack, sc);
      end
      repeat (2) @(negedge clk);
`endif
      do_xfer(1'b0, 32'h1008, 32'h0, 4'hF, 1, 32'h1357_9BDF, ack, err, d, m, f, sc, fwd);
      checks++;
      if (ack !== 1'b1 || err !== 1'b0 || d !== 32'h1357_9BDF || m !== 4'b0010) begin
         errors++;
         $display("FAIL post_watchdog_hit: ack=%b err=%b dat=%h mask=%b required 1/0/13579bdf/0010", ack, err, d, m);
      end
   endtask

   task automatic test_interrupts();
      @(negedge clk);
      bus.s2_int_i = 1'b1; bus.s3_int_i = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.m_int_o !== 1'b0) begin
         errors++;
         $display("FAIL int_unused_ports: int=%b required 0", bus.m_int_o);
      end
      bus.s1_int_i = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.m_int_o !== 1'b1) begin
         errors++;
         $display("FAIL int_s1: int=%b required 1", bus.m_int_o);
      end
      bus.s1_int_i = 1'b0; bus.s2_int_i = 1'b0; bus.s3_int_i = 1'b0;
      bus1.s1_int_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus1.m_int_o !== 1'b0 || bus.m_int_o !== 1'b0) begin
         errors++;
         $display("FAIL int_ns1_s1: int1=%b int=%b required 0/0", bus1.m_int_o, bus.m_int_o);
      end
      bus1.s0_int_i = 1'b1;
      #1;
      checks++;
      if (bus1.m_int_o !== 1'b0) begin
         errors++;
         $display("FAIL int_ns1_registered: int=%b required 0", bus1.m_int_o);
      end
      @(negedge clk);
      checks++;
      if (bus1.m_int_o !== 1'b1) begin
         errors++;
         $display("FAIL int_ns1_s0: int=%b required 1", bus1.m_int_o);
      end
      bus1.s0_int_i = 1'b0; bus1.s1_int_i = 1'b0;
   endtask

   initial begin
      bus.m_we_i = 0; bus.m_cyc_i = 0; bus.m_stb_i = 0; bus.m_sel_i = 0; bus.m_adr_i = 0; bus.m_dat_i = 0;
      bus.s0_ack_i = 0; bus.s0_int_i = 0; bus.s0_dat_i = 0;
      bus.s1_ack_i = 0; bus.s1_int_i = 0; bus.s1_dat_i = 0;
      bus.s2_ack_i = 0; bus.s2_int_i = 0; bus.s2_dat_i = 0;
      bus.s3_ack_i = 0; bus.s3_int_i = 0; bus.s3_dat_i = 0;
      bus1.m_we_i = 0; bus1.m_cyc_i = 0; bus1.m_stb_i = 0; bus1.m_sel_i = 0; bus1.m_adr_i = 0; bus1.m_dat_i = 0;
      bus1.s0_ack_i = 0; bus1.s0_int_i = 0; bus1.s0_dat_i = 0;
      bus1.s1_ack_i = 0; bus1.s1_int_i = 0; bus1.s1_dat_i = 0;
      bus1.s2_ack_i = 0; bus1.s2_int_i = 0; bus1.s2_dat_i = 0;
      bus1.s3_ack_i = 0; bus1.s3_int_i = 0; bus1.s3_dat_i = 0;
      test_reset();
      test_idle_ack_ignored();
      test_read_s1();
      test_boundary();
      test_miss();
      test_random();
      test_abort_and_reset();
      test_watchdog();
      test_interrupts();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/wishbone_mem_interconnect_n.md
WISHBONE_MEM_INTERCONNECT_N -- requirements
Module: wishbone_mem_interconnect_n

Interface
REQ-001 Parameter NUM_SLAVES, default 2, number of active slave ports, legal range 1..4.
REQ-002 Parameters MEM_OFFSET_0..MEM_OFFSET_3, default 0/32'h1000/32'h2000/32'h3000, base address of slave N.
REQ-003 Parameters MEM_SIZE_0..MEM_SIZE_3, default 4096 each, window size of slave N in address units.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, slave-ack watchdog limit; 16-bit counter.
REQ-005 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Ports m_we_i, m_cyc_i, m_stb_i, input, 1 each, master write enable, cycle and strobe.
REQ-008 Ports m_sel_i (4) and m_adr_i/m_dat_i (32), input, master byte select, address and write data.
REQ-009 Ports m_ack_o (1), m_dat_o (32), m_int_o (1), m_err_o (1), output, master ack, read data, interrupt and error pulse.
REQ-010 Ports sN_we_o, sN_cyc_o, sN_stb_o (1), sN_sel_o (4), sN_adr_o, sN_dat_o (32), output, N=0..3, slave request.
REQ-011 Ports sN_ack_i, sN_int_i (1), sN_dat_i (32), input, N=0..3, slave response.

Function
REQ-012 States SHALL be IDLE, ACTIVE, MISS_ACK, ERR_ACK.
REQ-013 IDLE with m_cyc_i&m_stb_i SHALL decode m_adr_i and register sel: lowest N<NUM_SLAVES with MEM_OFFSET_N <= adr < MEM_OFFSET_N+MEM_SIZE_N, 32-bit unsigned compare.
REQ-014 A hit SHALL move IDLE->ACTIVE; a miss SHALL move IDLE->MISS_ACK.
REQ-015 In ACTIVE, slave sel SHALL see m_we/stb/cyc/sel/adr/dat combinationally; all other slave outputs SHALL be 0.
REQ-016 In ACTIVE, m_ack_o and m_dat_o SHALL equal ssel_ack_i and ssel_dat_i combinationally; request-to-first-slave-strobe latency is 1 cycle.
REQ-017 ACTIVE with ssel_ack_i=1 SHALL move to IDLE; back-to-back requests SHALL each pay the 1-cycle decode.
REQ-018 ACTIVE with m_cyc_i=0 (abort) SHALL move to IDLE next edge with no ack to the master.
REQ-019 MISS_ACK SHALL assert m_ack_o=1 and m_dat_o=0 for exactly one cycle, touch no slave, then return to IDLE.
REQ-020 Outside ACTIVE/MISS_ACK/ERR_ACK, m_ack_o=0, m_err_o=0 and m_dat_o=0.
REQ-021 m_int_o SHALL be a registered OR of sN_int_i for N<NUM_SLAVES; ports N>=NUM_SLAVES SHALL drive 0 and their inputs SHALL be ignored.
REQ-022 A slave ack arriving in IDLE, MISS_ACK or ERR_ACK SHALL be ignored.

Reset
REQ-023 rst=0 SHALL immediately force IDLE, no slave selected, watchdog=0, m_int_o=0, all slave outputs 0.
REQ-024 Reset during ACTIVE SHALL abort the cycle with no ack; operation resumes on the first edge after rst=1.

Configuration
REQ-025 Macro WB_MEM_INTERCONNECT_TIMEOUT_EN defined: watchdog clears on ACTIVE entry and increments each ACTIVE cycle without ack.
REQ-026 With the macro, count reaching TIMEOUT_CYCLES with no ack SHALL move to ERR_ACK.
REQ-027 ERR_ACK SHALL drop slave strobe/cycle and drive m_ack_o=1, m_err_o=1, m_dat_o=32'hFFFFFFFF for one cycle, then return to IDLE.
REQ-028 An ack in the same cycle the limit is reached SHALL win: normal ack, no error.
REQ-029 Macro undefined: no watchdog or ERR_ACK state; ACTIVE waits indefinitely; m_err_o tied 0.

Verification
REQ-030 Read adr 32'h1004, s1 acks after 3 cycles with 32'hA5A5A5A5 -> s1_stb_o high 1 cycle after request; m_ack_o with m_dat_o=32'hA5A5A5A5; s0 untouched.
REQ-031 Write adr 32'h0FFF then 32'h1000 -> first goes to s0, second to s1 (window boundary); sel/dat forwarded unchanged.
REQ-032 Read adr 32'h8000 -> one-cycle m_ack_o, m_dat_o=0, m_err_o=0, no slave strobe.
REQ-033 Macro on, TIMEOUT_CYCLES=8, s0 never acks -> m_ack_o=1 and m_err_o=1 with 32'hFFFFFFFF; then IDLE; next hit served normally.
REQ-034 Mid-ACTIVE pull m_cyc_i low, then separately pull rst low -> both return to IDLE, no m_ack_o, slave outputs 0.
REQ-035 NUM_SLAVES=1, assert s1_int_i then s0_int_i -> m_int_o stays 0, then 1 one cycle after s0_int_i.
